// File: rtl/ext_bus_pkg.sv
// Shared definitions for the cpu external bus: control field layout, size codes,
// responder state encoding and the byte-lane helpers also used by the cpu load/store unit.
package ext_bus_pkg;

    localparam int CTRL_VALID_BIT = 3;
    localparam int CTRL_WRITE_BIT = 2;
    localparam int CTRL_SIZE_MSB  = 1;
    localparam int CTRL_SIZE_LSB  = 0;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'b00;
    localparam logic [1:0] BUS_SIZE_HALF = 2'b01;
    localparam logic [1:0] BUS_SIZE_WORD = 2'b10;
    localparam logic [1:0] BUS_SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // An all-zero result marks a misaligned or reserved-size access.
    function automatic logic [3:0] bus_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            BUS_SIZE_BYTE: be = 4'b0001 << addr_lo;
            BUS_SIZE_HALF: be = addr_lo[0] ? 4'b0000 : (4'b0011 << {addr_lo[1], 1'b0});
            BUS_SIZE_WORD: be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic bus_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (bus_byte_en(size, addr_lo) == 4'b0000);
    endfunction

    function automatic logic [31:0] bus_lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            BUS_SIZE_BYTE: d = {4{wdata[7:0]}};
            BUS_SIZE_HALF: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ext_bus_irq_timer.sv
// Periodic external interrupt: enabled-cycle counter plus a pending latch retired by grant.
module ext_bus_irq_timer
    import ext_bus_pkg::*;
#(
    parameter int IRQ_PERIOD = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic grant,
    output logic irq
);

    localparam int CNT_W = (IRQ_PERIOD > 2) ? $clog2(IRQ_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(IRQ_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             hold_q, hold_d;

    // hold_q makes the cycle right after a grant a dead cycle before counting resumes.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        hold_d = 1'b0;
        if (pend_q) begin
            if (grant) begin
                pend_d = 1'b0;
                hold_d = 1'b1;
            end
        end else if (!hold_q && enable) begin
            if (cnt_q == CNT_TC) begin
                pend_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            hold_q <= hold_d;
        end
    end

    assign irq = pend_q;

endmodule

// File: rtl/ext_bus_responder.sv
// External bus responder: word RAM with fixed read latency, byte-lane writes,
// alignment checking and the periodic external interrupt.
//
// state | meaning
// IDLE  | waiting for valid; a valid request is accepted and captured
// WAIT  | read latency padding; bus inputs ignored
// RESP  | last cycle of a transaction; read word registered as it is left
module ext_bus_responder
    import ext_bus_pkg::*;
#(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2,
    parameter int IRQ_PERIOD   = 100
) (
    input  logic        clk_from_external,
    input  logic        reset_from_external,
    input  logic [31:0] address_to_external_bus_from_cpu,
    input  logic [31:0] outputdata_to_external_bus,
    input  logic [3:0]  control_output_to_external_bus,
    input  logic        interrupt_grant_from_pc,
    input  logic        irq_enable,
    output logic [31:0] inputdata_from_external_bus,
    output logic        interrupt_from_external,
    output logic        bus_error
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [1:0] LAT_TC = 2'(READ_LATENCY - 1);

    bus_state_e state_q, state_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic       bus_error_q;
    logic       wr_pend_q;
    logic       accept;

    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic                 err_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rd_word;

    logic       req_valid;
    logic       req_write;
    logic [1:0] req_size;
    logic [1:0] req_addr_lo;
    logic       req_err;
    logic       unused_addr_bits;

    assign req_valid   = control_output_to_external_bus[CTRL_VALID_BIT];
    assign req_write   = control_output_to_external_bus[CTRL_WRITE_BIT];
    assign req_size    = control_output_to_external_bus[CTRL_SIZE_MSB:CTRL_SIZE_LSB];
    assign req_addr_lo = address_to_external_bus_from_cpu[1:0];
    assign req_err     = bus_misaligned(req_size, req_addr_lo);
    assign unused_addr_bits = ^address_to_external_bus_from_cpu[31:ADDR_BITS+2];

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        rdata_d   = rdata_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    lat_cnt_d = 2'd1;
                    state_d   = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_TC) begin
                    lat_cnt_d = 2'd0;
                    state_d   = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                lat_cnt_d = 2'd0;
                state_d   = ST_IDLE;
                if (err_q) begin
                    rdata_d = 32'd0;
                end else if (!write_q) begin
                    rdata_d = rd_word;
                end
            end
            default: begin
                lat_cnt_d = 2'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_from_external) begin
        if (reset_from_external) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 2'd0;
            rdata_q     <= 32'd0;
            bus_error_q <= 1'b0;
            wr_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            rdata_q     <= rdata_d;
            bus_error_q <= accept & req_err;
            wr_pend_q   <= accept & req_write & ~req_err;
        end
    end

    always_ff @(posedge clk_from_external) begin
        if (accept) begin
            addr_q  <= address_to_external_bus_from_cpu[ADDR_BITS+1:2];
            write_q <= req_write;
            err_q   <= req_err;
            be_q    <= bus_byte_en(req_size, req_addr_lo);
            wdata_q <= bus_lane_data(req_size, outputdata_to_external_bus);
        end
    end

    // No reset here on purpose: a write whose commit edge meets reset still lands.
    always_ff @(posedge clk_from_external) begin
        if (wr_pend_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem_q[addr_q];

    ext_bus_irq_timer #(
        .IRQ_PERIOD(IRQ_PERIOD)
    ) u_irq_timer (
        .clk    (clk_from_external),
        .reset  (reset_from_external),
        .enable (irq_enable),
        .grant  (interrupt_grant_from_pc),
        .irq    (interrupt_from_external)
    );

    assign inputdata_from_external_bus = rdata_q;
    assign bus_error                   = bus_error_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder: three instances (latency 2, 1 and 4) share one bus.
module tb_ext_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ctrl;
    logic        grant;
    logic        irq_en;

    logic [31:0] rd2, rd1, rd4;
    logic        irq2, irq1, irq4;
    logic        be2, be1, be4;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    always #5 clk = ~clk;

    ext_bus_responder #(.ADDR_BITS(10), .READ_LATENCY(2), .IRQ_PERIOD(100)) u_dut (
        .clk_from_external               (clk),
        .reset_from_external             (rst),
        .address_to_external_bus_from_cpu(addr),
        .outputdata_to_external_bus      (wdata),
        .control_output_to_external_bus  (ctrl),
        .interrupt_grant_from_pc         (grant),
        .irq_enable                      (irq_en),
        .inputdata_from_external_bus     (rd2),
        .interrupt_from_external         (irq2),
        .bus_error                       (be2)
    );

    ext_bus_responder #(.ADDR_BITS(10), .READ_LATENCY(1), .IRQ_PERIOD(100)) u_rl1 (
        .clk_from_external               (clk),
        .reset_from_external             (rst),
        .address_to_external_bus_from_cpu(addr),
        .outputdata_to_external_bus      (wdata),
        .control_output_to_external_bus  (ctrl),
        .interrupt_grant_from_pc         (grant),
        .irq_enable                      (irq_en),
        .inputdata_from_external_bus     (rd1),
        .interrupt_from_external         (irq1),
        .bus_error                       (be1)
    );

    ext_bus_responder #(.ADDR_BITS(10), .READ_LATENCY(4), .IRQ_PERIOD(100)) u_rl4 (
        .clk_from_external               (clk),
        .reset_from_external             (rst),
        .address_to_external_bus_from_cpu(addr),
        .outputdata_to_external_bus      (wdata),
        .control_output_to_external_bus  (ctrl),
        .interrupt_grant_from_pc         (grant),
        .irq_enable                      (irq_en),
        .inputdata_from_external_bus     (rd4),
        .interrupt_from_external         (irq4),
        .bus_error                       (be4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ctrl  = {1'b1, wr, sz};
        addr  = a;
        wdata = d;
    endtask

    task automatic bus_idle();
        ctrl = 4'd0;
    endtask

    // One complete latency-2 transaction; the latency-2 instance is back in IDLE afterwards.
    task automatic xact(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        drive(wr, sz, a, d);
        tick();
        bus_idle();
        tick();
        tick();
    endtask

    initial begin
        logic [11:0] obs1, obs2, obs4, exp1, exp2, exp4;
        int hi;

        rst    = 1'b1;
        addr   = 32'd0;
        wdata  = 32'd0;
        ctrl   = 4'd0;
        grant  = 1'b0;
        irq_en = 1'b0;

        repeat (3) tick();
        check("rst_rdata", rd2, 32'd0);
        check("rst_bus_error", 32'({be4, be1, be2}), 32'd0);
        check("rst_irq", 32'({irq4, irq1, irq2}), 32'd0);
        rst = 1'b0;

        // word write then read with latency 2
        drive(1'b1, SZ_W, 32'h8, 32'hDEADBEEF);
        tick();
        check("wr_word_no_err", 32'(be2), 32'd0);
        bus_idle();
        tick();
        tick();
        drive(1'b0, SZ_W, 32'h8, 32'h0);
        tick();
        bus_idle();
        check("rd_hold_edge0", rd2, 32'd0);
        tick();
        check("rd_hold_edge1", rd2, 32'd0);
        tick();
        check("rd_word_edge2", rd2, 32'hDEADBEEF);

        // byte and half merges into word 2
        xact(1'b1, SZ_B, 32'h9, 32'h000000AA);
        check("rd_kept_over_write", rd2, 32'hDEADBEEF);
        xact(1'b1, SZ_H, 32'hA, 32'h00001234);
        xact(1'b0, SZ_W, 32'h8, 32'h0);
        check("rd_merged_lanes", rd2, 32'h1234AAEF);

        xact(1'b1, SZ_W, 32'h4, 32'h11223344);
        xact(1'b0, SZ_W, 32'h4, 32'h0);
        check("rd_word1", rd2, 32'h11223344);

        // misaligned half write
        drive(1'b1, SZ_H, 32'h5, 32'hFFFFFFFF);
        tick();
        bus_idle();
        check("mis_half_err_pulse", 32'(be2), 32'd1);
        tick();
        check("mis_half_err_low", 32'(be2), 32'd0);
        tick();
        check("mis_half_rdata0", rd2, 32'd0);
        xact(1'b0, SZ_W, 32'h4, 32'h0);
        check("mis_half_ram_kept", rd2, 32'h11223344);

        // reserved size write
        drive(1'b1, SZ_R, 32'h4, 32'hFFFFFFFF);
        tick();
        bus_idle();
        check("rsvd_err_pulse", 32'(be2), 32'd1);
        tick();
        check("rsvd_err_low", 32'(be2), 32'd0);
        tick();
        check("rsvd_rdata0", rd2, 32'd0);
        xact(1'b0, SZ_W, 32'h4, 32'h0);
        check("rsvd_ram_kept", rd2, 32'h11223344);

        // misaligned word read
        drive(1'b0, SZ_W, 32'h6, 32'h0);
        tick();
        bus_idle();
        check("mis_word_err_pulse", 32'(be2), 32'd1);
        tick();
        tick();
        check("mis_word_rdata0", rd2, 32'd0);

        // upper address bits are ignored
        xact(1'b0, SZ_W, 32'hFFFFF008, 32'h0);
        check("rd_upper_bits_ignored", rd2, 32'h1234AAEF);

        // reset while a read sits in WAIT
        drive(1'b0, SZ_W, 32'h4, 32'h0);
        tick();
        bus_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_wait_rdata", rd2, 32'd0);
        drive(1'b0, SZ_W, 32'h4, 32'h0);
        tick();
        bus_idle();
        check("rd_after_rst_edge0", rd2, 32'd0);
        tick();
        check("rd_after_rst_edge1", rd2, 32'd0);
        tick();
        check("rd_after_rst_edge2", rd2, 32'h11223344);

        // write whose commit edge coincides with reset
        drive(1'b1, SZ_W, 32'hC, 32'h55AA55AA);
        tick();
        bus_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        xact(1'b0, SZ_W, 32'hC, 32'h0);
        check("wr_commit_under_rst", rd2, 32'h55AA55AA);

        // interrupt period from reset release; a stray grant mid-count is ignored
        rst    = 1'b1;
        irq_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (49) tick();
        grant = 1'b1;
        tick();
        grant = 1'b0;
        repeat (49) tick();
        check("irq_low_edge99", 32'(irq2), 32'd0);
        tick();
        check("irq_high_edge100", 32'(irq2), 32'd1);
        hi = 0;
        repeat (20) begin
            tick();
            if (irq2 === 1'b1) hi++;
        end
        check("irq_held_20", 32'(hi), 32'd20);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("irq_cleared_on_grant", 32'(irq2), 32'd0);
        repeat (100) tick();
        check("irq_low_grant_plus100", 32'(irq2), 32'd0);
        tick();
        check("irq_high_grant_plus101", 32'(irq2), 32'd1);
        irq_en = 1'b0;
        repeat (5) tick();
        check("irq_pending_kept_disabled", 32'(irq2), 32'd1);

        // counter freezes while disabled
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("irq_cleared_disabled", 32'(irq2), 32'd0);
        repeat (50) tick();
        irq_en = 1'b1;
        repeat (99) tick();
        check("irq_frozen_low", 32'(irq2), 32'd0);
        tick();
        check("irq_frozen_high", 32'(irq2), 32'd1);
        irq_en = 1'b0;

        // valid held high: re-acceptance cadence per latency, seen through bus_error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, SZ_R, 32'h0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            tick();
            obs1[k] = be1;
            obs2[k] = be2;
            obs4[k] = be4;
            exp1[k] = ((k % 2) == 0);
            exp2[k] = ((k % 3) == 0);
            exp4[k] = ((k % 5) == 0);
        end
        bus_idle();
        check("cadence_rl1", 32'(obs1), 32'(exp1));
        check("cadence_rl2", 32'(obs2), 32'(exp2));
        check("cadence_rl4", 32'(obs4), 32'(exp4));

        // read latency for the 1- and 4-edge instances
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, SZ_W, 32'h10, 32'hCAFEF00D);
        tick();
        bus_idle();
        repeat (5) tick();
        drive(1'b0, SZ_W, 32'h10, 32'h0);
        tick();
        bus_idle();
        check("rl1_edge0", rd1, 32'd0);
        tick();
        check("rl1_edge1", rd1, 32'hCAFEF00D);
        tick();
        tick();
        check("rl4_edge3", rd4, 32'd0);
        tick();
        check("rl4_edge4", rd4, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
